fifo_sync_param: RTL and testbench
==================================

// Module: fifo_sync_param
// PURPOSE
//  Parametrised single-clock FIFO; next generation of the team's basic write/read FIFO.
//  Adds configurable width/depth, fill count, programmable almost-full/almost-empty,
//  overflow/underflow pulses, and a selectable first-word-fall-through (FWFT) read mode.
//  Sits between producer/consumer blocks in one clock domain as a rate-smoothing buffer.
// PARAMETERS
//  WIDTH_DATA  8    data word width, >=1
//  DEPTH       16   number of entries, power of two, >=4
//  AF_LEVEL    12   almost_full_o asserted when count >= AF_LEVEL (1..DEPTH-1)
//  AE_LEVEL    4    almost_empty_o asserted when count <= AE_LEVEL (0..DEPTH-2, < AF_LEVEL)
//  FWFT        0    0 = standard read (1-cycle latency), 1 = first-word-fall-through
// PORTS
//  clk_i           in   1               single clock, all logic on rising edge
//  rst_i           in   1               reset, synchronous, active-high
//  write_i         in   1               write request
//  data_i          in   WIDTH_DATA      write data, sampled with write_i
//  read_i          in   1               read request (FWFT: pop/acknowledge of data_o)
//  data_o          out  WIDTH_DATA      read data
//  empty_o         out  1               no entries
//  full_o          out  1               DEPTH entries
//  almost_empty_o  out  1               count <= AE_LEVEL
//  almost_full_o   out  1               count >= AF_LEVEL
//  count_o         out  $clog2(DEPTH)+1 current number of entries, 0..DEPTH
//  overflow_o      out  1               1-cycle pulse: a write was rejected
//  underflow_o     out  1               1-cycle pulse: a read was rejected
// BEHAVIOUR
//  - Reset (rst_i=1 at edge): pointers=0, count_o=0, empty_o=1, almost_empty_o=1, full_o=0,
//    almost_full_o=0, overflow_o=0, underflow_o=0, data_o=0. Reset wins over write/read;
//    reset mid-operation discards all contents, no pulses generated on that edge.
//  - Accept rules per edge: wr_acc = write_i & (!full_o | read_i);  rd_acc = read_i & !empty_o.
//    Full + read + write: both accepted, count unchanged. Empty + read + write: write only,
//    read rejected (underflow_o pulse), count +1.
//  - count_o next = count + wr_acc - rd_acc; all flags are registered, derived from next count,
//    valid in the same cycle as the new count_o (no extra lag).
//  - Pointers ADDR_W=$clog2(DEPTH) bits, wrap naturally DEPTH-1 -> 0; full/empty from count_o.
//  - overflow_o = registered (write_i & !wr_acc); underflow_o = registered (read_i & !rd_acc);
//    high exactly one cycle per rejected request.
//  - FWFT=0: on rd_acc at edge N, data_o <= mem[rd_ptr] at edge N; data_o holds last read word
//    otherwise (not cleared on empty).
//  - FWFT=1: data_o = mem[rd_ptr] combinationally whenever !empty_o (word visible before read_i);
//    read_i pops it. A word written at edge N appears on data_o after edge N when FIFO was empty.
//    data_o content is don't-care while empty_o=1.
//  - Memory has no reset; only control state is reset.
// STRUCTURE
//  - fifo_pkg: function cnt_w(depth) = $clog2(depth)+1; typedef for read-mode enum
//    (FIFO_STD, FIFO_FWFT).
//  - Sub-module fifo_ram: WIDTH_DATA x DEPTH, one sync write port, one async read port.
//  - Top: pointer/count/flag logic, output register (FWFT=0) or bypass (FWFT=1), via generate.
//  - Parameter legality checked with elaboration-time $error.
// TESTING (WIDTH_DATA=8, DEPTH=16, AF=12, AE=4; both FWFT=0 and FWFT=1 builds)
//  1 Reset: hold rst_i 2 cycles -> empty_o=1, count_o=0, full_o=0, data_o=8'h00, no pulses.
//  2 Fill: 16 writes 8'h01..8'h10 -> almost_empty_o drops at count 5, almost_full_o rises
//    at 12, full_o=1 at 16; 17th write (8'hFF) -> overflow_o 1 cycle, count_o stays 16.
//  3 Drain: 16 reads -> data 8'h01..8'h10 in order (FWFT=0: one cycle after each read);
//    17th read -> underflow_o 1 cycle, empty_o=1, count_o=0.
//  4 Full + read + write 8'hAA -> no overflow, count_o=16, 8'hAA read out 16th after.
//  5 Empty + read + write 8'h55 -> underflow_o pulse, count_o=1; FWFT=1: data_o=8'h55 next cycle.
//  6 Wrap: 40 cycles simultaneous read/write at count 3 -> count_o constant 3, order kept;
//    rst_i mid-stream -> count_o=0, empty_o=1 next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared types and sizing helpers for the parametrised sync FIFO.
// Revision : 1.0
// ============================================================================
package fifo_pkg;

    typedef enum logic [0:0] {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } read_mode_e;

    // Count must represent 0..DEPTH inclusive, hence one bit beyond the address.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ram
// Purpose  : WIDTH_DATA x DEPTH storage, one synchronous write, one async read.
// Revision : 1.0
// ============================================================================
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH_DATA = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [WIDTH_DATA-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [WIDTH_DATA-1:0] rd_data
);

    // Storage is intentionally not reset; only the control path is.
    logic [WIDTH_DATA-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_param
// Purpose  : Single-clock FIFO with fill count, programmable thresholds,
//            overflow/underflow pulses and selectable standard/FWFT read.
// Revision : 1.0
// ============================================================================
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int WIDTH_DATA = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 4,
    parameter int FWFT       = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     write_i,
    input  logic [WIDTH_DATA-1:0]    data_i,
    input  logic                     read_i,
    output logic [WIDTH_DATA-1:0]    data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     almost_empty_o,
    output logic                     almost_full_o,
    output logic [cnt_w(DEPTH)-1:0]  count_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);

    localparam int         ADDR_W = $clog2(DEPTH);
    localparam int         CNT_W  = cnt_w(DEPTH);
    localparam read_mode_e MODE   = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    // ------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------
    if (WIDTH_DATA < 1) begin : g_bad_width
        $error("fifo_sync_param: WIDTH_DATA must be >= 1");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_sync_param: DEPTH must be a power of two >= 4");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH - 1) begin : g_bad_af
        $error("fifo_sync_param: AF_LEVEL must be in 1..DEPTH-1");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 2 || AE_LEVEL >= AF_LEVEL) begin : g_bad_ae
        $error("fifo_sync_param: AE_LEVEL must be in 0..DEPTH-2 and < AF_LEVEL");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $error("fifo_sync_param: FWFT must be 0 or 1");
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic                  overflow;
    logic                  underflow;

    logic                  wr_acc;
    logic                  rd_acc;
    logic [CNT_W-1:0]      count_next;
    logic [WIDTH_DATA-1:0] ram_rdata;

    // A full FIFO still takes a write when a read frees a slot on the same edge.
    assign wr_acc     = write_i & (~full | read_i);
    assign rd_acc     = read_i & ~empty;
    assign count_next = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == CNT_W'(DEPTH));
            almost_empty <= (count_next <= CNT_W'(AE_LEVEL));
            almost_full  <= (count_next >= CNT_W'(AF_LEVEL));
            overflow     <= write_i & ~wr_acc;
            underflow    <= read_i & ~rd_acc;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    fifo_ram #(
        .WIDTH_DATA (WIDTH_DATA),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk     (clk_i),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (data_i),
        .rd_addr (rd_ptr),
        .rd_data (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------
    if (MODE == FIFO_FWFT) begin : g_fwft
        // Head word is presented before it is popped; zero while empty.
        assign data_o = empty ? '0 : ram_rdata;
    end else begin : g_std
        logic [WIDTH_DATA-1:0] data_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                data_q <= '0;
            end else if (rd_acc) begin
                data_q <= ram_rdata;
            end
        end

        assign data_o = data_q;
    end

    assign empty_o        = empty;
    assign full_o         = full;
    assign almost_empty_o = almost_empty;
    assign almost_full_o  = almost_full;
    assign count_o        = count;
    assign overflow_o     = overflow;
    assign underflow_o    = underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_sync_param
// Purpose  : Scoreboard bench driving a standard and an FWFT instance in lockstep.
// Revision : 1.0
// ============================================================================
module tb_fifo_sync_param;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AF = 12;
    localparam int AE = 4;

    logic         clk = 1'b0;
    logic         rst_i = 1'b0;
    logic         write_i = 1'b0;
    logic         read_i = 1'b0;
    logic [W-1:0] data_i = '0;

    logic [W-1:0] s_data, f_data;
    logic         s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
    logic         f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
    logic [4:0]   s_count, f_count;

    always #5 clk = ~clk;

    fifo_sync_param #(.WIDTH_DATA(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
        .clk_i(clk), .rst_i(rst_i), .write_i(write_i), .data_i(data_i), .read_i(read_i),
        .data_o(s_data), .empty_o(s_empty), .full_o(s_full), .almost_empty_o(s_ae),
        .almost_full_o(s_af), .count_o(s_count), .overflow_o(s_ovf), .underflow_o(s_unf)
    );

    fifo_sync_param #(.WIDTH_DATA(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
        .clk_i(clk), .rst_i(rst_i), .write_i(write_i), .data_i(data_i), .read_i(read_i),
        .data_o(f_data), .empty_o(f_empty), .full_o(f_full), .almost_empty_o(f_ae),
        .almost_full_o(f_af), .count_o(f_count), .overflow_o(f_ovf), .underflow_o(f_unf)
    );

    logic [W-1:0] q[$];
    logic [W-1:0] last_std = '0;
    logic         exp_ovf = 1'b0;
    logic         exp_unf = 1'b0;
    int           checks = 0;
    int           errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock of stimulus: update the model, clock, then compare both instances.
    task automatic step(input logic r, input logic w, input logic [W-1:0] d, input logic rd);
        logic wacc, racc;
        int   n;
        rst_i   = r;
        write_i = w;
        data_i  = d;
        read_i  = rd;
        wacc = w && (q.size() < D || rd);
        racc = rd && (q.size() != 0);
        if (r) begin
            q.delete();
            last_std = '0;
            exp_ovf  = 1'b0;
            exp_unf  = 1'b0;
        end else begin
            exp_ovf = w && !wacc;
            exp_unf = rd && !racc;
            if (racc) last_std = q.pop_front();
            if (wacc) q.push_back(d);
        end
        @(posedge clk);
        #1;
        n = q.size();
        check_eq("std.count", 32'(s_count), 32'(n));
        check_eq("std.empty", 32'(s_empty), 32'(n == 0));
        check_eq("std.full",  32'(s_full),  32'(n == D));
        check_eq("std.ae",    32'(s_ae),    32'(n <= AE));
        check_eq("std.af",    32'(s_af),    32'(n >= AF));
        check_eq("std.ovf",   32'(s_ovf),   32'(exp_ovf));
        check_eq("std.unf",   32'(s_unf),   32'(exp_unf));
        check_eq("std.data",  32'(s_data),  32'(last_std));
        check_eq("fwft.count", 32'(f_count), 32'(n));
        check_eq("fwft.empty", 32'(f_empty), 32'(n == 0));
        check_eq("fwft.full",  32'(f_full),  32'(n == D));
        check_eq("fwft.ae",    32'(f_ae),    32'(n <= AE));
        check_eq("fwft.af",    32'(f_af),    32'(n >= AF));
        check_eq("fwft.ovf",   32'(f_ovf),   32'(exp_ovf));
        check_eq("fwft.unf",   32'(f_unf),   32'(exp_unf));
        if (n != 0) check_eq("fwft.head", 32'(f_data), 32'(q[0]));
        rst_i   = 1'b0;
        write_i = 1'b0;
        read_i  = 1'b0;
    endtask

    initial begin
        // Reset held for two cycles
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h77, 1'b1);
        check_eq("reset.fwft.data", 32'(f_data), 32'h0);

        // Fill 01..10, then a rejected write
        for (int i = 1; i <= D; i++) step(1'b0, 1'b1, W'(i), 1'b0);
        step(1'b0, 1'b1, 8'hFF, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Drain in order, then a rejected read
        for (int i = 0; i < D; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Full + read + write: both taken, AA emerges last
        for (int i = 0; i < D; i++) step(1'b0, 1'b1, 8'h20 + W'(i), 1'b0);
        step(1'b0, 1'b1, 8'hAA, 1'b1);
        for (int i = 0; i < D; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

        // Empty + read + write: write only, read rejected
        step(1'b0, 1'b1, 8'h55, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Wrap at constant occupancy of 3
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hC0 + W'(i), 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, W'($urandom_range(0, 255)), 1'b1);

        // Reset mid-stream, then confirm normal operation resumes
        step(1'b1, 1'b1, 8'h99, 1'b1);
        step(1'b0, 1'b1, 8'h3C, 1'b0);
        step(1'b0, 1'b1, 8'h3D, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
